display_page_ctrl: RTL and testbench
====================================

DISPLAY_PAGE_CTRL -- requirements
Module: display_page_ctrl

Interface
REQ-001 Parameter DEBOUNCE_CYCLES, default 1000000, number of consecutive stable cycles (10 ms at 100 MHz) required to accept a button level change.
REQ-002 Parameter AUTO_CYCLES, default 200000000, number of cycles per page in auto-scroll mode (2 s at 100 MHz).
REQ-003 clk  input  1  system clock (100 MHz); this is the block's only clock.
REQ-004 rst_n  input  1  reset; asynchronous assertion, active-low.
REQ-005 btn_next  input  1  raw asynchronous push-button, active-high, advances the page.
REQ-006 btn_prev  input  1  raw asynchronous push-button, active-high, steps the page back.
REQ-007 auto_en  input  1  synchronous level; 1 enables auto-scroll through the pages.
REQ-008 data_in  input  128  result word to display.
REQ-009 data_valid  input  1  single-cycle strobe qualifying data_in.
REQ-010 data_out  output  128  registered held copy of the last captured data_in; drives the display controller data input.
REQ-011 digit_sel  output  3  registered page index 0-3; drives the display controller group select.
REQ-012 page_led  output  4  one-hot page indicator; bit n set when digit_sel==n.
REQ-013 fresh  output  1  registered flag, set when new data has been captured and not yet acknowledged by a button press.

Function
REQ-014 Each button SHALL pass through a 2-flop synchronizer before any other logic uses it.
REQ-015 Each button SHALL have an independent debouncer: a stable-state register plus a counter; the counter clears whenever the synchronized level equals the stable state.
REQ-016 The counter SHALL increment while the levels differ; the stable state SHALL toggle, and the counter SHALL clear, on the edge where the levels differ and the counter equals DEBOUNCE_CYCLES-1.
REQ-017 A press event SHALL occur on the edge where a stable state goes 0->1; 1->0 transitions produce no event.
REQ-018 Press-to-update latency: digit_sel SHALL update on the (DEBOUNCE_CYCLES+2)th rising edge counting the first edge that samples the raw button high, provided the button is held throughout.
REQ-019 A glitch shorter than DEBOUNCE_CYCLES synchronized cycles SHALL produce no event.
REQ-020 A next event SHALL set page to (page+1) mod 4, so 3 wraps to 0.
REQ-021 A prev event SHALL set page to (page-1) mod 4, so 0 wraps to 3.
REQ-022 Simultaneous next and prev events SHALL leave the page unchanged.
REQ-023 digit_sel[2] SHALL be held at 0 at all times.
REQ-024 Any button event SHALL clear fresh and clear the auto timer.
REQ-025 The auto timer SHALL be held at 0 while auto_en=0.
REQ-026 While auto_en=1, the auto timer SHALL increment each cycle; at AUTO_CYCLES-1 it SHALL advance the page by +1 mod 4 and clear to 0.
REQ-027 When data_valid=1, the block SHALL, on that edge, set data_out to data_in, set digit_sel to 0, clear the auto timer and set fresh to 1.
REQ-028 A data_valid event SHALL take priority over any coincident button or auto event; a button event that is discarded this way does not clear fresh.
REQ-029 A button event coincident with an auto advance SHALL apply only the button action.
REQ-030 page_led SHALL be derived combinationally from digit_sel and be exactly one-hot.

Reset
REQ-031 On rst_n=0, the following SHALL asynchronously clear: data_out=0, digit_sel=0, page_led=4'b0001, fresh=0, all synchronizer flops, stable states and counters, and the auto timer.
REQ-032 Reset asserted mid-debounce or mid-auto-count SHALL discard the partial count.
REQ-033 After rst_n deasserts, a button already held high SHALL produce exactly one event after the REQ-018 latency.

Verification (bench parameters: DEBOUNCE_CYCLES=4, AUTO_CYCLES=10)
REQ-034 Reset, then data_valid with data_in=128'h00112233_44556677_8899AABB_CCDDEEFF -> next edge: data_out equals data_in, digit_sel=0, fresh=1.
REQ-035 Hold btn_next for 20 cycles -> digit_sel goes 0->1 exactly on the 6th edge and fresh goes to 0; four separate presses from page 0 -> 1,2,3,0.
REQ-036 btn_next high for 3 cycles then low -> no page change; btn_prev press at page 0 -> digit_sel=3 and page_led=4'b1000.
REQ-037 auto_en=1 from page 2 -> page 3 after 10 cycles, then page 0 after 10 more; a data_valid strobe in the cycle of an auto advance -> digit_sel=0 and the timer restarts.
REQ-038 Both buttons pressed in the same cycle -> page unchanged; rst_n pulsed low during the 3rd debounce cycle -> all outputs at reset values and no event afterwards.

Source files
------------

// File: rtl/display_page_ctrl.sv
// Page selector for a 4-page result display.
// Two debounced push-buttons step the page, an optional auto-scroll timer
// advances it, and a data_valid strobe captures a new result word and returns
// to page 0.
module display_page_ctrl #(
  parameter int unsigned DEBOUNCE_CYCLES = 1000000,
  parameter int unsigned AUTO_CYCLES     = 200000000
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         btn_next,
  input  logic         btn_prev,
  input  logic         auto_en,
  input  logic [127:0] data_in,
  input  logic         data_valid,
  output logic [127:0] data_out,
  output logic [2:0]   digit_sel,
  output logic [3:0]   page_led,
  output logic         fresh
);

  localparam int unsigned CntW  = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam int unsigned AutoW = (AUTO_CYCLES > 1) ? $clog2(AUTO_CYCLES) : 1;
  localparam logic [CntW-1:0]  CntLast  = CntW'(DEBOUNCE_CYCLES - 1);
  localparam logic [AutoW-1:0] AutoLast = AutoW'(AUTO_CYCLES - 1);

  // Index 0 is btn_next, index 1 is btn_prev.
  logic [1:0]      btn_raw;
  logic [1:0]      sync1_q, sync2_q;
  logic [1:0]      stable_q, stable_d;
  logic [CntW-1:0] cnt_q [2];
  logic [CntW-1:0] cnt_d [2];
  logic [1:0]      press;

  logic [1:0]       page_q, page_d;
  logic [AutoW-1:0] timer_q, timer_d;
  logic             fresh_q, fresh_d;
  logic [127:0]     data_q, data_d;

  assign btn_raw = {btn_prev, btn_next};

  // Two-flop synchronizers, debounce stable state and counters.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q  <= '0;
      sync2_q  <= '0;
      stable_q <= '0;
      cnt_q    <= '{default: '0};
    end else begin
      sync1_q  <= btn_raw;
      sync2_q  <= sync1_q;
      stable_q <= stable_d;
      cnt_q    <= cnt_d;
    end
  end

  // Debounce: count cycles the synchronized level disagrees with the stable
  // state; accept the new level once the disagreement has lasted long enough.
  always_comb begin
    stable_d = stable_q;
    press    = '0;
    for (int b = 0; b < 2; b++) begin
      cnt_d[b] = '0;
      if (sync2_q[b] != stable_q[b]) begin
        if (cnt_q[b] == CntLast) begin
          stable_d[b] = ~stable_q[b];
          // Only the rising acceptance counts as a press.
          press[b]    = ~stable_q[b];
        end else begin
          cnt_d[b] = cnt_q[b] + CntW'(1);
        end
      end
    end
  end

  // Page, auto timer, fresh flag and captured data registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      page_q  <= '0;
      timer_q <= '0;
      fresh_q <= 1'b0;
      data_q  <= '0;
    end else begin
      page_q  <= page_d;
      timer_q <= timer_d;
      fresh_q <= fresh_d;
      data_q  <= data_d;
    end
  end

  // Priority: data capture, then button events, then auto-scroll.
  always_comb begin
    page_d  = page_q;
    timer_d = timer_q;
    fresh_d = fresh_q;
    data_d  = data_q;
    if (data_valid) begin
      data_d  = data_in;
      page_d  = 2'd0;
      timer_d = '0;
      fresh_d = 1'b1;
    end else if (|press) begin
      fresh_d = 1'b0;
      timer_d = '0;
      case (press)
        2'b01:   page_d = page_q + 2'd1;
        2'b10:   page_d = page_q - 2'd1;
        default: page_d = page_q;  // both at once cancel out
      endcase
    end else if (!auto_en) begin
      timer_d = '0;
    end else if (timer_q == AutoLast) begin
      page_d  = page_q + 2'd1;
      timer_d = '0;
    end else begin
      timer_d = timer_q + AutoW'(1);
    end
  end

  assign data_out  = data_q;
  assign digit_sel = {1'b0, page_q};
  assign page_led  = 4'b0001 << page_q;
  assign fresh     = fresh_q;

endmodule

// File: tb/tb_display_page_ctrl.sv
// Bench for display_page_ctrl with short debounce/auto periods.
// Directed scenarios check fixed expectations; a random phase compares the DUT
// with a window-based behavioural model running alongside.
module tb_display_page_ctrl;

  localparam int unsigned D = 4;
  localparam int unsigned A = 10;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         btn_next = 1'b0;
  logic         btn_prev = 1'b0;
  logic         auto_en = 1'b0;
  logic [127:0] data_in = '0;
  logic         data_valid = 1'b0;
  logic [127:0] data_out;
  logic [2:0]   digit_sel;
  logic [3:0]   page_led;
  logic         fresh;

  int checks = 0;
  int errors = 0;

  display_page_ctrl #(
    .DEBOUNCE_CYCLES(D),
    .AUTO_CYCLES    (A)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .btn_next  (btn_next),
    .btn_prev  (btn_prev),
    .auto_en   (auto_en),
    .data_in   (data_in),
    .data_valid(data_valid),
    .data_out  (data_out),
    .digit_sel (digit_sel),
    .page_led  (page_led),
    .fresh     (fresh)
  );

  always #5 clk = ~clk;

  // ---------------- behavioural model ----------------
  // A level is accepted once the last D synchronized samples (raw samples two
  // edges old) all disagree with the currently accepted level.
  bit [D:0]     hist_n, hist_p;   // [0] = raw at previous edge
  bit           acc_lvl_n, acc_lvl_p;
  int           m_page, m_timer;
  bit           m_fresh;
  logic [127:0] m_data;
  logic         m_flip_n, m_flip_p, m_ev_n, m_ev_p;

  function automatic bit window_differs(input bit [D:0] h, input bit lvl);
    for (int j = 1; j <= int'(D); j++) if (h[j] == lvl) return 1'b0;
    return 1'b1;
  endfunction

  assign m_flip_n = window_differs(hist_n, acc_lvl_n);
  assign m_flip_p = window_differs(hist_p, acc_lvl_p);
  assign m_ev_n   = m_flip_n & ~acc_lvl_n;
  assign m_ev_p   = m_flip_p & ~acc_lvl_p;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hist_n <= '0; hist_p <= '0; acc_lvl_n <= 1'b0; acc_lvl_p <= 1'b0;
      m_page <= 0; m_timer <= 0; m_fresh <= 1'b0; m_data <= '0;
    end else begin
      hist_n    <= {hist_n[D-1:0], btn_next};
      hist_p    <= {hist_p[D-1:0], btn_prev};
      acc_lvl_n <= acc_lvl_n ^ m_flip_n;
      acc_lvl_p <= acc_lvl_p ^ m_flip_p;
      if (data_valid) begin
        m_data <= data_in; m_page <= 0; m_timer <= 0; m_fresh <= 1'b1;
      end else if (m_ev_n || m_ev_p) begin
        m_fresh <= 1'b0; m_timer <= 0;
        m_page  <= (m_page + int'(m_ev_n) - int'(m_ev_p) + 4) % 4;
      end else if (auto_en) begin
        if (m_timer == int'(A) - 1) begin
          m_page <= (m_page + 1) % 4; m_timer <= 0;
        end else begin
          m_timer <= m_timer + 1;
        end
      end else begin
        m_timer <= 0;
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    rst_n = 1'b0;
    #3;
    checks++;
    if (data_out !== '0 || digit_sel !== 3'd0 || page_led !== 4'b0001 || fresh !== 1'b0) begin
      errors++;
      $display("FAIL reset: data_out=%h digit_sel=%0d page_led=%b fresh=%b want 0/0/0001/0",
               data_out, digit_sel, page_led, fresh);
    end
    tick(2);
    rst_n = 1'b1;
    tick(1);
  endtask

  task automatic test_capture();
    data_in    = 128'h00112233_44556677_8899AABB_CCDDEEFF;
    data_valid = 1'b1;
    tick(1);
    data_valid = 1'b0;
    checks++;
    if (data_out !== 128'h00112233_44556677_8899AABB_CCDDEEFF || digit_sel !== 3'd0 ||
        fresh !== 1'b1) begin
      errors++;
      $display("FAIL capture: data_out=%h digit_sel=%0d fresh=%b want data_in/0/1",
               data_out, digit_sel, fresh);
    end
  endtask

  task automatic test_next_hold();
    btn_next = 1'b1;
    for (int i = 1; i <= 20; i++) begin
      tick(1);
      checks++;
      if (digit_sel !== ((i >= 6) ? 3'd1 : 3'd0) || fresh !== ((i >= 6) ? 1'b0 : 1'b1)) begin
        errors++;
        $display("FAIL next_hold edge %0d: digit_sel=%0d fresh=%b want %0d/%b",
                 i, digit_sel, fresh, (i >= 6) ? 1 : 0, (i >= 6) ? 1'b0 : 1'b1);
      end
    end
    btn_next = 1'b0;
    tick(8);
  endtask

  task automatic test_four_presses();
    data_valid = 1'b1;
    tick(1);
    data_valid = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      btn_next = 1'b1;
      tick(6);
      btn_next = 1'b0;
      tick(7);
      checks++;
      if (digit_sel !== 3'(k % 4)) begin
        errors++;
        $display("FAIL four_presses #%0d: digit_sel=%0d want %0d", k, digit_sel, k % 4);
      end
    end
  endtask

  task automatic test_glitch_and_prev();
    btn_next = 1'b1;
    tick(3);
    btn_next = 1'b0;
    tick(10);
    checks++;
    if (digit_sel !== 3'd0) begin
      errors++;
      $display("FAIL glitch: digit_sel=%0d want 0", digit_sel);
    end
    btn_prev = 1'b1;
    tick(6);
    btn_prev = 1'b0;
    checks++;
    if (digit_sel !== 3'd3 || page_led !== 4'b1000) begin
      errors++;
      $display("FAIL prev_wrap: digit_sel=%0d page_led=%b want 3/1000", digit_sel, page_led);
    end
    tick(7);
  endtask

  task automatic test_auto();
    logic [2:0] exp;
    btn_prev = 1'b1;
    tick(6);
    btn_prev = 1'b0;
    tick(7);
    checks++;
    if (digit_sel !== 3'd2) begin
      errors++;
      $display("FAIL auto_setup: digit_sel=%0d want 2", digit_sel);
    end
    auto_en = 1'b1;
    for (int i = 1; i <= 29; i++) begin
      tick(1);
      exp = (i < 10) ? 3'd2 : (i < 20) ? 3'd3 : 3'd0;
      checks++;
      if (digit_sel !== exp) begin
        errors++;
        $display("FAIL auto edge %0d: digit_sel=%0d want %0d", i, digit_sel, exp);
      end
    end
    // Edge 30 would be an auto advance; the capture must win.
    data_in    = 128'hDEADBEEF_01234567_89ABCDEF_FEEDFACE;
    data_valid = 1'b1;
    tick(1);
    data_valid = 1'b0;
    checks++;
    if (digit_sel !== 3'd0 || fresh !== 1'b1 ||
        data_out !== 128'hDEADBEEF_01234567_89ABCDEF_FEEDFACE) begin
      errors++;
      $display("FAIL auto_vs_valid: digit_sel=%0d fresh=%b data_out=%h want 0/1/new",
               digit_sel, fresh, data_out);
    end
    for (int i = 31; i <= 40; i++) begin
      tick(1);
      exp = (i < 40) ? 3'd0 : 3'd1;
      checks++;
      if (digit_sel !== exp) begin
        errors++;
        $display("FAIL auto_restart edge %0d: digit_sel=%0d want %0d", i, digit_sel, exp);
      end
    end
    auto_en = 1'b0;
  endtask

  task automatic test_both();
    btn_next = 1'b1;
    btn_prev = 1'b1;
    tick(6);
    btn_next = 1'b0;
    btn_prev = 1'b0;
    checks++;
    if (digit_sel !== 3'd1 || fresh !== 1'b0) begin
      errors++;
      $display("FAIL both: digit_sel=%0d fresh=%b want 1/0", digit_sel, fresh);
    end
    tick(8);
  endtask

  task automatic test_reset_mid_debounce();
    btn_next = 1'b1;
    tick(3);
    rst_n = 1'b0;
    #2;
    checks++;
    if (data_out !== '0 || digit_sel !== 3'd0 || page_led !== 4'b0001 || fresh !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid: data_out=%h digit_sel=%0d page_led=%b fresh=%b want 0/0/0001/0",
               data_out, digit_sel, page_led, fresh);
    end
    tick(1);
    rst_n = 1'b1;
    // Too short to be accepted unless the pre-reset count leaked through.
    tick(3);
    btn_next = 1'b0;
    tick(10);
    checks++;
    if (digit_sel !== 3'd0) begin
      errors++;
      $display("FAIL reset_mid_no_event: digit_sel=%0d want 0", digit_sel);
    end
  endtask

  task automatic test_held_through_reset();
    btn_next = 1'b1;
    tick(2);
    rst_n = 1'b0;
    tick(1);
    rst_n = 1'b1;
    for (int i = 1; i <= 20; i++) begin
      tick(1);
      checks++;
      if (digit_sel !== ((i >= 6) ? 3'd1 : 3'd0)) begin
        errors++;
        $display("FAIL held_reset edge %0d: digit_sel=%0d want %0d",
                 i, digit_sel, (i >= 6) ? 1 : 0);
      end
    end
    btn_next = 1'b0;
    tick(8);
  endtask

  task automatic test_random();
    int hold_n = 0, hold_p = 0, hold_a = 0;
    for (int c = 0; c < 1500; c++) begin
      if (hold_n == 0) begin btn_next = 1'($urandom); hold_n = $urandom_range(1, 10); end
      if (hold_p == 0) begin btn_prev = 1'($urandom); hold_p = $urandom_range(1, 10); end
      if (hold_a == 0) begin auto_en = 1'($urandom); hold_a = $urandom_range(5, 60); end
      hold_n--; hold_p--; hold_a--;
      data_valid = ($urandom_range(0, 24) == 0);
      data_in    = {$urandom, $urandom, $urandom, $urandom};
      tick(1);
      checks++;
      if (digit_sel !== 3'(m_page) || page_led !== 4'(1 << m_page) || fresh !== m_fresh ||
          data_out !== m_data) begin
        errors++;
        $display("FAIL random cycle %0d: sel=%0d led=%b fresh=%b data=%h want %0d/%b/%b/%h",
                 c, digit_sel, page_led, fresh, data_out, m_page, 4'(1 << m_page), m_fresh,
                 m_data);
      end
    end
    btn_next = 1'b0; btn_prev = 1'b0; auto_en = 1'b0; data_valid = 1'b0;
  endtask

  initial begin
    test_reset();
    test_capture();
    test_next_hold();
    test_four_presses();
    test_glitch_and_prev();
    test_auto();
    test_both();
    test_reset_mid_debounce();
    test_held_through_reset();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
